// File: rtl/pilha_param.sv
// rtl/pilha_param.sv - parametrised LIFO operand stack (UC/ULA push source, registered pop, replace-top)
// Optional build macro: PILHA_ERRO_STICKY_EN (sticky overflow/underflow flags cleared by clr_erro)
module pilha_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ULA_W  = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              sel_ula,
  input  logic [DATA_W-1:0] din_uc,
  input  logic [ULA_W-1:0]  din_ula,
  input  logic              clr_erro,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  tos,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  tos_q;
  logic [CNT_W-1:0]  tos_m1;
  logic [CNT_W-1:0]  tos_nxt;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     push_idx;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wd;
  logic              wr_en;
  logic              dout_ld;
  logic              ovf_evt;
  logic              unf_evt;

  assign tos      = tos_q;
  assign full     = (tos_q == CNT_W'(DEPTH));
  assign empty    = (tos_q == '0);
  assign tos_m1   = tos_q - CNT_W'(1);
  assign top_idx  = tos_m1[AW-1:0];
  assign push_idx = tos_q[AW-1:0];
  assign wd       = sel_ula ? din_ula[DATA_W-1:0] : din_uc;
  assign top      = empty ? '0 : mem[top_idx];

  // Upper ALU bits are intentionally dropped on push.
  if (ULA_W > DATA_W) begin : g_ula_hi
    logic unused_ula_hi;
    assign unused_ula_hi = ^din_ula[ULA_W-1:DATA_W];
  end

  // Decode the {push,pop} request into write, pointer and error actions.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = push_idx;
    tos_nxt = tos_q;
    dout_ld = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en   = 1'b1;
          tos_nxt = tos_q + CNT_W'(1);
        end else begin
          ovf_evt = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          dout_ld = 1'b1;
          tos_nxt = tos_m1;
        end else begin
          unf_evt = 1'b1;
        end
      end
      2'b11: begin
        if (!empty) begin
          // Replace-top: old top goes out, new word overwrites it.
          dout_ld = 1'b1;
          wr_en   = 1'b1;
          wr_idx  = top_idx;
        end else begin
          // Empty stack: behaves as a plain push.
          wr_en   = 1'b1;
          tos_nxt = tos_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Storage array; writes are suppressed while reset is held so an aborted request leaves no trace.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[wr_idx] <= wd;
    end
  end

  // Occupancy and registered pop output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_q <= '0;
      dout  <= '0;
    end else begin
      tos_q <= tos_nxt;
      if (dout_ld) begin
        dout <= mem[top_idx];
      end
    end
  end

`ifdef PILHA_ERRO_STICKY_EN
  // Sticky error flags: an event sets, clr_erro clears, set wins over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow & ~clr_erro);
      underflow <= unf_evt | (underflow & ~clr_erro);
    end
  end
`else
  logic unused_clr_erro;
  assign unused_clr_erro = clr_erro;

  // Pulse error flags: high for the one cycle after the refused request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt;
      underflow <= unf_evt;
    end
  end
`endif

endmodule
